// File: rtl/quant_seq_pkg.sv
// Shared constants for the quantize sequencer.
//   - Mode encodings seen on i_job_mode / o_q_mode.
//   - Geometry defaults (vector length, matrix dims, VSQ buffer depth) that
//     set the sequencer's default beat counts.
package quant_seq_pkg;

    // Quantize mode encodings
    localparam logic [1:0] MODE_INT4_VSQ = 2'd0;
    localparam logic [1:0] MODE_INT4     = 2'd1;
    localparam logic [1:0] MODE_INT8     = 2'd2;

    // Geometry defaults
    localparam int VL        = 16;
    localparam int M         = 32;
    localparam int N         = 4;
    localparam int VSQ_BUF_D = 4;

    // True when the mode scans one vector at a time instead of the whole tensor
    function automatic logic is_vsq(input logic [1:0] mode);
        return mode == MODE_INT4_VSQ;
    endfunction

endpackage

// File: rtl/quant_seq.sv
// Quantize job sequencer.
// Accepts a job, scans the source for the max statistic (whole tensor for
// INT4/INT8, one vector at a time for INT4_VSQ), then kicks the quantize unit
// once per vector and waits for its vector-done / matrix-finish handshakes.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_job_valid/mode    job request and its quantize mode
//   o_job_ready         sequencer idle, job accepted on valid
//   i_src_valid         source beat present during scan
//   o_src_ready         beat consumed this cycle (scan state)
//   o_q_mode            latched job mode to the quantize unit
//   o_q_start           one-cycle start pulse per vector
//   o_q_max_done        one-cycle end-of-tensor-scan pulse (INT4/INT8)
//   i_q_vec_done        quantize unit finished a vector
//   i_q_finish          quantize unit finished the matrix (expected in FIN)
//   o_busy, o_done      job in progress / one-cycle completion pulse
//   o_err               sticky protocol error, cleared only by reset
module quant_seq
    import quant_seq_pkg::*;
#(
    parameter int COL_BEATS = (M / VL) * N,
    parameter int VSQ_D     = VSQ_BUF_D,
    parameter int MAX_LAT   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_job_valid,
    input  logic [1:0] i_job_mode,
    output logic       o_job_ready,
    input  logic       i_src_valid,
    output logic       o_src_ready,
    output logic [1:0] o_q_mode,
    output logic       o_q_start,
    output logic       o_q_max_done,
    input  logic       i_q_vec_done,
    input  logic       i_q_finish,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int NVEC = COL_BEATS / VSQ_D;
    localparam int BW   = $clog2(COL_BEATS + 1);
    localparam int VW   = $clog2(NVEC + 1);
    localparam int LW   = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_MAXW, S_ARM, S_QUANT, S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic            max_done;
    logic [BW-1:0]   scan_last_idx;

    // VSQ scans a single vector's worth of beats per round
    assign scan_last_idx = is_vsq(mode_q) ? BW'(VSQ_D - 1) : BW'(COL_BEATS - 1);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        beat_d   = beat_q;
        vec_d    = vec_q;
        lat_d    = lat_q;
        err_d    = err_q;
        done_d   = 1'b0;
        max_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_job_valid) begin
                    mode_d  = i_job_mode;
                    beat_d  = '0;
                    vec_d   = '0;
                    lat_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (i_src_valid) begin
                    if (beat_q == scan_last_idx) begin
                        beat_d = '0;
                        if (is_vsq(mode_q)) begin
                            state_d = S_ARM;
                        end else begin
                            max_done = 1'b1;
                            lat_d    = '0;
                            state_d  = S_MAXW;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_MAXW: begin
                if (lat_q == LW'(MAX_LAT - 1)) state_d = S_ARM;
                else                           lat_d   = lat_q + 1'b1;
            end
            S_ARM: begin
                state_d = S_QUANT;
            end
            S_QUANT: begin
                if (i_q_vec_done) begin
                    vec_d = vec_q + 1'b1;
                    if (vec_q == VW'(NVEC - 1))  state_d = S_FIN;
                    else if (is_vsq(mode_q))     state_d = S_SCAN;
                    else                         state_d = S_ARM;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (!i_q_finish) err_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Handshakes arriving in the wrong state are flagged and otherwise ignored
        if (i_q_finish && state_q != S_FIN)     err_d = 1'b1;
        if (i_q_vec_done && state_q != S_QUANT) err_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_INT8;
            beat_q  <= '0;
            vec_q   <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
            vec_q   <= vec_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign o_job_ready  = (state_q == S_IDLE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_src_ready  = (state_q == S_SCAN);
    assign o_q_start    = (state_q == S_ARM);
    assign o_q_max_done = max_done;
    assign o_q_mode     = mode_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_quant_seq.sv
module tb_quant_seq;
    import quant_seq_pkg::*;

    localparam int COL_BEATS = 8;
    localparam int VSQ_D     = 4;
    localparam int MAX_LAT   = 4;
    localparam int T         = 4000;

    logic       clk = 1'b0;
    logic       rst;
    logic       job_valid, src_valid, q_vec_done, q_finish;
    logic [1:0] job_mode;
    logic       job_ready, src_ready, q_start, q_max_done, busy, done, err;
    logic [1:0] q_mode;

    always #5 clk = ~clk;

    quant_seq #(.COL_BEATS(COL_BEATS), .VSQ_D(VSQ_D), .MAX_LAT(MAX_LAT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_job_valid(job_valid), .i_job_mode(job_mode), .o_job_ready(job_ready),
        .i_src_valid(src_valid), .o_src_ready(src_ready),
        .o_q_mode(q_mode), .o_q_start(q_start), .o_q_max_done(q_max_done),
        .i_q_vec_done(q_vec_done), .i_q_finish(q_finish),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    // Timeline of stimulus and expected outputs, indexed by cycle
    logic       jv[T], sv[T], vd[T], fin[T];
    logic [1:0] jm[T], e_mode[T];
    logic       e_start[T], e_maxd[T], e_done[T], e_busy[T], e_srdy[T];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int last_a = 1, cur_done = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Job schedule from the sequencing rules: scan counts only valid beats,
    // max wait MAX_LAT, one start per vector, vec_done some cycles later,
    // FIN right after the last vec_done, done one cycle after FIN.
    task automatic plan_job(input int a, input logic [1:0] m, input bit tog);
        int c, ones, len, t0;
        jv[a] = 1'b1;
        jm[a] = m;
        if (tog) for (int i = 0; i < 2*COL_BEATS + 2; i++) sv[a+1+i] = (i % 2 == 0);
        c = a + 1;
        for (int v = 0; v < COL_BEATS / VSQ_D; v++) begin
            if (v == 0 || m == MODE_INT4_VSQ) begin
                len  = (m == MODE_INT4_VSQ) ? VSQ_D : COL_BEATS;
                ones = 0;
                t0   = c;
                forever begin
                    if (c - t0 > 3*COL_BEATS) sv[c] = 1'b1;
                    e_srdy[c] = 1'b1;
                    if (sv[c]) ones++;
                    if (ones == len) break;
                    c++;
                end
                if (m != MODE_INT4_VSQ) begin
                    e_maxd[c] = 1'b1;
                    c += MAX_LAT;
                end
                c++;
            end
            e_start[c] = 1'b1;
            c += 1 + int'($urandom_range(0, 3));
            vd[c] = 1'b1;
            c++;
        end
        fin[c] = 1'b1;
        e_done[c+1] = 1'b1;
        for (int i = a + 1; i <= c; i++) begin
            e_busy[i] = 1'b1;
            e_mode[i] = m;
        end
        last_a   = a;
        cur_done = c + 1;
    endtask

    // gap 0: request held high through the previous job, accepted at its done cycle
    task automatic next_job(input logic [1:0] m, input int gap, input bit tog);
        int a;
        a = cur_done + gap;
        if (gap == 0) for (int c = last_a + 1; c <= a; c++) jv[c] = 1'b1;
        plan_job(a, m, tog);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit ok;
        logic [1:0] m;
        rst = 1'b1; job_valid = 0; job_mode = 0; src_valid = 0; q_vec_done = 0; q_finish = 0;

        for (int i = 0; i < T; i++) begin
            jv[i] = 0; vd[i] = 0; fin[i] = 0;
            sv[i] = ($urandom_range(0, 3) != 0);
            jm[i] = 2'($urandom_range(0, 2));
            e_mode[i] = 0; e_start[i] = 0; e_maxd[i] = 0; e_done[i] = 0;
            e_busy[i] = 0; e_srdy[i] = 0;
        end

        next_job(MODE_INT8,     1, 1'b1);   // toggling src_valid
        next_job(MODE_INT4_VSQ, 3, 1'b0);
        next_job(MODE_INT4,     0, 1'b0);   // back-to-back, request held
        next_job(MODE_INT8,     0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            m = 2'($urandom_range(0, 2));
            next_job(m, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_src_rdy", src_ready, 0);
        chk("rst_job_rdy", job_ready, 1);
        chk("rst_mode", q_mode, MODE_INT8);
        chk("rst_err", err, 0);
        chk("rst_start", q_start, 0);
        chk("rst_done", done, 0);
        #4;

        for (int k = 0; k < cur_done + 3; k++) begin
            cyc = k;
            job_valid = jv[k]; job_mode = jm[k]; src_valid = sv[k];
            q_vec_done = vd[k]; q_finish = fin[k];
            @(negedge clk);
            chk("busy", busy, e_busy[k]);
            chk("job_rdy", job_ready, !e_busy[k]);
            chk("src_rdy", src_ready, e_srdy[k]);
            chk("start", q_start, e_start[k]);
            chk("max_done", q_max_done, e_maxd[k]);
            chk("done", done, e_done[k]);
            chk("err", err, 0);
            if (e_busy[k]) chk("mode", q_mode, e_mode[k]);
            step();
        end
        job_valid = 0; src_valid = 0; q_vec_done = 0; q_finish = 0;
        cyc = -1;

        // vec_done while idle: flagged, otherwise ignored
        q_vec_done = 1'b1;
        step();
        q_vec_done = 1'b0;
        @(negedge clk);
        chk("vd_idle_err", err, 1);
        chk("vd_idle_busy", busy, 0);
        step();
        do_reset();
        @(negedge clk);
        chk("err_clr", err, 0);
        step();

        // finish outside FIN
        q_finish = 1'b1;
        step();
        q_finish = 1'b0;
        @(negedge clk);
        chk("fin_idle_err", err, 1);
        step();
        do_reset();

        // INT8 job whose FIN sees no finish -> sticky error
        job_valid = 1'b1; job_mode = MODE_INT8; src_valid = 1'b1;
        step();
        job_valid = 1'b0;
        for (int v = 0; v < COL_BEATS / VSQ_D; v++) begin
            wait_start(ok);
            chk("nofin_start", ok, 1);
            step();
            q_vec_done = 1'b1;
            step();
            q_vec_done = 1'b0;
        end
        @(negedge clk);
        chk("nofin_in_fin_busy", busy, 1);
        step();
        @(negedge clk);
        chk("nofin_err", err, 1);
        chk("nofin_idle", busy, 0);
        repeat (5) step();
        @(negedge clk);
        chk("nofin_err_sticky", err, 1);
        step();
        do_reset();
        @(negedge clk);
        chk("nofin_err_clr", err, 0);
        step();

        // reset during QUANT aborts with no done
        job_valid = 1'b1; job_mode = MODE_INT4_VSQ;
        step();
        job_valid = 1'b0;
        wait_start(ok);
        chk("abort_start", ok, 1);
        step();
        @(negedge clk);
        chk("abort_in_quant", busy, 1);
        chk("abort_mode", q_mode, MODE_INT4_VSQ);
        step();
        do_reset();
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_job_rdy", job_ready, 1);
        chk("abort_src_rdy", src_ready, 0);
        chk("abort_mode_rst", q_mode, MODE_INT8);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            step();
        end
        chk("abort_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
